// File: rtl/hier_tree_pkg.sv
// Shared types and helpers for the hierarchy tree node and its arbiter.
package hier_tree_pkg;

    typedef enum logic [1:0] {
        IDLE,
        UCAST,
        BCAST
    } req_state_e;

    // Index width that never collapses to zero bits for tiny counts.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hier_rr_arbiter.sv
// Round-robin arbiter: searches req from the rotating pointer, grants one-hot when advance is high.
module hier_rr_arbiter
    import hier_tree_pkg::*;
#(
    parameter int N     = 10,
    parameter int IDX_W = clog2_min1(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [IDX_W-1:0] ptr;
    logic             found;
    int               j;

    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        j         = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && req[j]) begin
                found     = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
    end

    always_comb begin
        grant       = '0;
        grant_valid = advance && found;
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // The pointer moves past the winner so it has lowest priority next time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (grant_valid) begin
            if (grant_idx == IDX_W'(N - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= grant_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hier_tree_node.sv
// Hierarchy node: fans parent requests out to children (unicast/broadcast), merges child
// responses back through a round-robin arbiter and tracks how many responses are still owed.
module hier_tree_node
    import hier_tree_pkg::*;
#(
    parameter int NUM_CHILDREN    = 10,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 16,
    parameter int IDX_W           = clog2_min1(NUM_CHILDREN),
    parameter int CNT_W           = clog2_min1(MAX_OUTSTANDING + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           up_req_valid,
    output logic                           up_req_ready,
    input  logic                           up_req_bcast,
    input  logic [IDX_W-1:0]               up_req_dest,
    input  logic [DATA_W-1:0]              up_req_data,
    output logic [NUM_CHILDREN-1:0]        dn_req_valid,
    input  logic [NUM_CHILDREN-1:0]        dn_req_ready,
    output logic [DATA_W-1:0]              dn_req_data,
    input  logic [NUM_CHILDREN-1:0]        dn_rsp_valid,
    output logic [NUM_CHILDREN-1:0]        dn_rsp_ready,
    input  logic [NUM_CHILDREN*DATA_W-1:0] dn_rsp_data,
    output logic                           up_rsp_valid,
    input  logic                           up_rsp_ready,
    output logic [DATA_W-1:0]              up_rsp_data,
    output logic [IDX_W-1:0]               up_rsp_src,
    output logic [CNT_W-1:0]               outstanding,
    output logic                           err_bad_dest,
    output logic                           err_unexp
);

    localparam int SUM_W = CNT_W + 7;

    req_state_e              state, state_nxt;
    logic [NUM_CHILDREN-1:0] done_mask, done_nxt;
    logic [IDX_W-1:0]        dest_q;
    logic [CNT_W-1:0]        inc_amt;
    logic                    accept;
    logic                    bad_dest_nxt;
    logic                    dest_ok;
    logic [SUM_W-1:0]        need;
    logic                    fits;

    logic [NUM_CHILDREN-1:0] grant;
    logic [IDX_W-1:0]        grant_idx;
    logic                    grant_valid;
    logic                    can_load;
    logic [DATA_W-1:0]       sel_data;
    logic                    dec;

    assign dest_ok = (32'(up_req_dest) < 32'(NUM_CHILDREN));
    assign need    = up_req_bcast ? SUM_W'(NUM_CHILDREN) : SUM_W'(1);
    assign fits    = (SUM_W'(outstanding) + need) <= SUM_W'(MAX_OUTSTANDING);

    // Request FSM: the counter is credited only once every addressed child has taken the request.
    always_comb begin
        state_nxt    = state;
        done_nxt     = done_mask;
        dn_req_valid = '0;
        up_req_ready = 1'b0;
        inc_amt      = '0;
        accept       = 1'b0;
        bad_dest_nxt = 1'b0;
        case (state)
            IDLE: begin
                up_req_ready = fits;
                if (up_req_valid && fits) begin
                    accept = 1'b1;
                    if (up_req_bcast) begin
                        state_nxt = BCAST;
                        done_nxt  = '0;
                    end else if (dest_ok) begin
                        state_nxt = UCAST;
                    end else begin
                        bad_dest_nxt = 1'b1;
                    end
                end
            end
            UCAST: begin
                dn_req_valid[dest_q] = 1'b1;
                if (dn_req_ready[dest_q]) begin
                    inc_amt   = CNT_W'(1);
                    state_nxt = IDLE;
                end
            end
            BCAST: begin
                dn_req_valid = ~done_mask;
                done_nxt     = done_mask | dn_req_ready;
                if (&done_nxt) begin
                    inc_amt   = CNT_W'(NUM_CHILDREN);
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            done_mask    <= '0;
            dest_q       <= '0;
            dn_req_data  <= '0;
            err_bad_dest <= 1'b0;
        end else begin
            state        <= state_nxt;
            done_mask    <= done_nxt;
            err_bad_dest <= bad_dest_nxt;
            if (accept) begin
                dest_q      <= up_req_dest;
                dn_req_data <= up_req_data;
            end
        end
    end

    // A new response may be granted whenever the output slot is free or empties this cycle.
    assign can_load = !up_rsp_valid || up_rsp_ready;

    hier_rr_arbiter #(
        .N     (NUM_CHILDREN),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (dn_rsp_valid),
        .advance     (can_load),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign dn_rsp_ready = grant;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_CHILDREN; i++) begin
            if (grant[i]) begin
                sel_data = dn_rsp_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_rsp_valid <= 1'b0;
            up_rsp_data  <= '0;
            up_rsp_src   <= '0;
        end else if (grant_valid) begin
            up_rsp_valid <= 1'b1;
            up_rsp_data  <= sel_data;
            up_rsp_src   <= grant_idx;
        end else if (up_rsp_ready) begin
            up_rsp_valid <= 1'b0;
        end
    end

    // An unexpected response is still forwarded but must not drive the counter below zero.
    assign dec = grant_valid && (outstanding != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
            err_unexp   <= 1'b0;
        end else begin
            outstanding <= outstanding + inc_amt - CNT_W'(dec);
            err_unexp   <= grant_valid && (outstanding == '0);
        end
    end

endmodule

// File: tb/tb_hier_tree_node.sv
// Directed bench for hier_tree_node (10 children, 32-bit data, 16 outstanding).
module tb_hier_tree_node;

    localparam int N  = 10;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int CW = 5;

    logic            clk;
    logic            rst_n;
    logic            up_req_valid;
    logic            up_req_ready;
    logic            up_req_bcast;
    logic [IW-1:0]   up_req_dest;
    logic [DW-1:0]   up_req_data;
    logic [N-1:0]    dn_req_valid;
    logic [N-1:0]    dn_req_ready;
    logic [DW-1:0]   dn_req_data;
    logic [N-1:0]    dn_rsp_valid;
    logic [N-1:0]    dn_rsp_ready;
    logic [N*DW-1:0] dn_rsp_data;
    logic            up_rsp_valid;
    logic            up_rsp_ready;
    logic [DW-1:0]   up_rsp_data;
    logic [IW-1:0]   up_rsp_src;
    logic [CW-1:0]   outstanding;
    logic            err_bad_dest;
    logic            err_unexp;

    int           n_checks;
    int           n_fail;
    logic [N-1:0] granted;
    logic [N-1:0] exp_mask;

    hier_tree_node #(
        .NUM_CHILDREN    (N),
        .DATA_W          (DW),
        .MAX_OUTSTANDING (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .up_req_valid (up_req_valid),
        .up_req_ready (up_req_ready),
        .up_req_bcast (up_req_bcast),
        .up_req_dest  (up_req_dest),
        .up_req_data  (up_req_data),
        .dn_req_valid (dn_req_valid),
        .dn_req_ready (dn_req_ready),
        .dn_req_data  (dn_req_data),
        .dn_rsp_valid (dn_rsp_valid),
        .dn_rsp_ready (dn_rsp_ready),
        .dn_rsp_data  (dn_rsp_data),
        .up_rsp_valid (up_rsp_valid),
        .up_rsp_ready (up_rsp_ready),
        .up_rsp_data  (up_rsp_data),
        .up_rsp_src   (up_rsp_src),
        .outstanding  (outstanding),
        .err_bad_dest (err_bad_dest),
        .err_unexp    (err_unexp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; children drop any response the node granted at that edge.
    task automatic tick();
        granted = dn_rsp_ready;
        @(posedge clk);
        #1;
        dn_rsp_valid = dn_rsp_valid & ~granted;
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        up_req_valid = 1'b0;
        up_req_bcast = 1'b0;
        up_req_dest  = '0;
        up_req_data  = '0;
        dn_req_ready = '0;
        dn_rsp_valid = '0;
        up_rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            dn_rsp_data[i*DW +: DW] = 32'h100 + i;
        end

        tick();
        tick();
        check_output("rst_up_req_ready", up_req_ready, 1);
        check_output("rst_dn_req_valid", dn_req_valid, 0);
        check_output("rst_outstanding", outstanding, 0);
        check_output("rst_up_rsp_valid", up_rsp_valid, 0);
        check_output("rst_errs", {err_bad_dest, err_unexp}, 0);
        rst_n = 1'b1;
        tick();

        // Unicast to child 3, accepted on the second cycle it is offered.
        up_req_valid = 1'b1;
        up_req_bcast = 1'b0;
        up_req_dest  = 4'd3;
        up_req_data  = 32'hA5;
        #1;
        check_output("uc_req_ready", up_req_ready, 1);
        tick();
        up_req_valid = 1'b0;
        #1;
        check_output("uc_valid_c1", dn_req_valid, 10'h008);
        check_output("uc_data", dn_req_data, 32'hA5);
        check_output("uc_busy", up_req_ready, 0);
        tick();
        check_output("uc_valid_c2", dn_req_valid, 10'h008);
        dn_req_ready = 10'h008;
        tick();
        dn_req_ready = '0;
        #1;
        check_output("uc_valid_done", dn_req_valid, 0);
        check_output("uc_outstanding", outstanding, 1);
        check_output("uc_ready_again", up_req_ready, 1);

        // Broadcast, children accept one per cycle from 9 down to 0.
        up_req_valid = 1'b1;
        up_req_bcast = 1'b1;
        up_req_data  = 32'h1234;
        #1;
        check_output("bc_req_ready", up_req_ready, 1);
        tick();
        up_req_valid = 1'b0;
        up_req_bcast = 1'b0;
        #1;
        check_output("bc_busy", up_req_ready, 0);
        exp_mask = 10'h3FF;
        for (int k = N - 1; k >= 0; k--) begin
            dn_req_ready = '0;
            dn_req_ready[k] = 1'b1;
            #1;
            check_output($sformatf("bc_valid_k%0d", k), dn_req_valid, exp_mask);
            check_output($sformatf("bc_data_k%0d", k), dn_req_data, 32'h1234);
            tick();
            exp_mask[k] = 1'b0;
        end
        dn_req_ready = '0;
        #1;
        check_output("bc_valid_done", dn_req_valid, 0);
        check_output("bc_outstanding", outstanding, 11);
        check_output("bc_ready_again", up_req_ready, 1);

        // Children 2, 5, 7 respond together; pointer starts at 0.
        dn_rsp_valid = 10'h0A4;
        up_rsp_ready = 1'b1;
        #1;
        check_output("rr_first_grant", dn_rsp_ready, 10'h004);
        tick();
        check_output("rr_v1", up_rsp_valid, 1);
        check_output("rr_src1", up_rsp_src, 2);
        check_output("rr_data1", up_rsp_data, 32'h102);
        check_output("rr_grant2", dn_rsp_ready, 10'h020);
        tick();
        check_output("rr_src2", up_rsp_src, 5);
        check_output("rr_data2", up_rsp_data, 32'h105);
        tick();
        check_output("rr_src3", up_rsp_src, 7);
        check_output("rr_outstanding", outstanding, 8);
        tick();
        check_output("rr_drained", up_rsp_valid, 0);

        // Unicast to a nonexistent child.
        up_req_valid = 1'b1;
        up_req_dest  = 4'd12;
        up_req_data  = 32'hDEAD;
        #1;
        check_output("bd_req_ready", up_req_ready, 1);
        tick();
        up_req_valid = 1'b0;
        #1;
        check_output("bd_err_pulse", err_bad_dest, 1);
        check_output("bd_no_valid", dn_req_valid, 0);
        check_output("bd_outstanding", outstanding, 8);
        tick();
        check_output("bd_err_clear", err_bad_dest, 0);
        check_output("bd_idle", up_req_ready, 1);

        // Child 0 responds with parent stalled; pointer is at 8 so it wraps to 0.
        dn_rsp_valid = 10'h001;
        up_rsp_ready = 1'b0;
        #1;
        check_output("bp_grant0", dn_rsp_ready, 10'h001);
        tick();
        check_output("bp_src0", up_rsp_src, 0);
        check_output("bp_outstanding7", outstanding, 7);
        up_req_valid = 1'b1;
        up_req_bcast = 1'b1;
        up_req_data  = 32'hBEEF;
        #1;
        check_output("bp_full_7p10", up_req_ready, 0);
        tick();
        check_output("bp_hold_valid", up_rsp_valid, 1);
        check_output("bp_hold_data", up_rsp_data, 32'h100);
        check_output("bp_still_full", up_req_ready, 0);
        check_output("bp_not_sent", dn_req_valid, 0);
        dn_rsp_valid = 10'h002;
        up_rsp_ready = 1'b1;
        #1;
        check_output("bp_grant1", dn_rsp_ready, 10'h002);
        tick();
        check_output("bp_src1", up_rsp_src, 1);
        check_output("bp_outstanding6", outstanding, 6);
        check_output("bp_fits_6p10", up_req_ready, 1);
        tick();
        up_req_valid = 1'b0;
        up_req_bcast = 1'b0;
        #1;
        check_output("rb_bcast_valid", dn_req_valid, 10'h3FF);
        check_output("rb_bcast_data", dn_req_data, 32'hBEEF);
        check_output("rb_rsp_drained", up_rsp_valid, 0);
        dn_req_ready = 10'h3C0;
        tick();
        dn_req_ready = '0;
        #1;
        check_output("rb_partial", dn_req_valid, 10'h03F);

        // Reset in the middle of the broadcast.
        rst_n = 1'b0;
        #1;
        check_output("rb_valid_clr", dn_req_valid, 0);
        check_output("rb_ready_set", up_req_ready, 1);
        check_output("rb_outstanding", outstanding, 0);
        check_output("rb_data_clr", dn_req_data, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Response with nothing outstanding: forwarded, flagged, counter stays 0.
        dn_rsp_valid = 10'h010;
        #1;
        check_output("ux_grant4", dn_rsp_ready, 10'h010);
        tick();
        check_output("ux_valid", up_rsp_valid, 1);
        check_output("ux_src", up_rsp_src, 4);
        check_output("ux_err", err_unexp, 1);
        check_output("ux_outstanding", outstanding, 0);
        tick();
        check_output("ux_err_clear", err_unexp, 0);

        // Fresh unicast after reset release.
        up_req_valid = 1'b1;
        up_req_dest  = 4'd9;
        up_req_data  = 32'h77;
        dn_req_ready = 10'h200;
        #1;
        check_output("pr_req_ready", up_req_ready, 1);
        tick();
        up_req_valid = 1'b0;
        #1;
        check_output("pr_valid", dn_req_valid, 10'h200);
        check_output("pr_data", dn_req_data, 32'h77);
        tick();
        dn_req_ready = '0;
        #1;
        check_output("pr_outstanding", outstanding, 1);
        check_output("pr_valid_done", dn_req_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
